// File: rtl/ipdc_ctrl.sv
// ipdc_ctrl: op sequencer, pixel loader and display-window read-address/strobe generator for ipdc.
// Build macro IPDC_MEDIAN_EN adds op 1001 (3x3 median reads) and the o_rd_pad output.
module ipdc_ctrl #(
   parameter int IMG_W     = 16,
   parameter int RD_LAT    = 1,
   parameter int DP_LAT    = 1,
   parameter int SIZE_INIT = 4,
   localparam int AW       = 2 * $clog2(IMG_W)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_op_valid,
   input  logic [3:0]    i_op_mode,
   output logic          o_op_ready,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   output logic          o_sram_wen,
   output logic          o_sram_ren,
   output logic [AW-1:0] o_sram_addr,
   output logic [1:0]    o_dp_mode,
   output logic          o_out_valid,
`ifdef IPDC_MEDIAN_EN
   output logic          o_rd_pad,
`endif
   output logic          o_out_last
);

   localparam int LW   = AW / 2;
   localparam int WW   = LW + 2;
   localparam int NPIX = IMG_W * IMG_W;
   localparam int OL   = RD_LAT + DP_LAT;
   localparam logic [WW-1:0] IMG_WW = WW'(IMG_W);

   typedef enum logic [2:0] {S_RDY, S_WAIT, S_LOAD, S_DISP, S_DRAIN} state_t;

   state_t          state, nstate;
   logic            armed;
   logic [LW-1:0]   win_x, win_y, nx, ny;
   logic [3:0]      win_size, ns;
   logic [1:0]      mode, nm;
   logic [AW:0]     pix_cnt;
   logic [3:0]      row_cnt, col_cnt;
   logic [OL-1:0]   vld_sr, last_sr;
   logic [WW-1:0]   xw, yw, sw, rd_row, rd_col;
   logic            accept, in_rdy, grp_end, win_end, step_vld;
`ifdef IPDC_MEDIAN_EN
   logic [1:0]      nb_r, nb_c;
   logic [WW-1:0]   prow, pcol;
`endif

   assign accept   = i_op_valid && ((state == S_RDY && armed) || state == S_WAIT);
   assign in_rdy   = (state == S_LOAD) && (pix_cnt < (AW+1)'(NPIX));
   assign win_end  = (row_cnt == win_size - 4'd1) && (col_cnt == win_size - 4'd1);
`ifdef IPDC_MEDIAN_EN
   assign grp_end  = (mode != 2'd2) || (nb_r == 2'd2 && nb_c == 2'd2);
`else
   assign grp_end  = 1'b1;
`endif
   assign step_vld = (state == S_DISP) && grp_end;

   assign xw = WW'(win_x);
   assign yw = WW'(win_y);
   assign sw = WW'(win_size);

   // Candidate window for the op on the input; an illegal result leaves the window as is.
   always_comb begin
      nx = win_x;
      ny = win_y;
      ns = win_size;
      nm = mode;
      case (i_op_mode)
         4'd1: if (xw + sw < IMG_WW) nx = win_x + LW'(1);
         4'd2: if (win_x != '0) nx = win_x - LW'(1);
         4'd3: if (win_y != '0) ny = win_y - LW'(1);
         4'd4: if (yw + sw < IMG_WW) ny = win_y + LW'(1);
         4'd5: if (win_size > 4'd2) ns = win_size >> 1;
         4'd6: if (win_size < 4'd8 && xw + (sw << 1) <= IMG_WW && yw + (sw << 1) <= IMG_WW)
                  ns = win_size << 1;
         4'd7: nm = 2'd1;
         4'd8: nm = 2'd0;
`ifdef IPDC_MEDIAN_EN
         4'd9: nm = 2'd2;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_RDY;
      else          state <= nstate;
   end

   // RDY holds until the first edge after reset release so the ready pulse is never seen in reset.
   always_comb begin
      nstate = state;
      case (state)
         S_RDY:   if (armed) nstate = accept ? ((i_op_mode == 4'd0) ? S_LOAD : S_DISP) : S_WAIT;
         S_WAIT:  if (accept) nstate = (i_op_mode == 4'd0) ? S_LOAD : S_DISP;
         S_LOAD:  if (in_rdy && i_in_valid && pix_cnt == (AW+1)'(NPIX - 1)) nstate = S_RDY;
         S_DISP:  if (step_vld && win_end) nstate = S_DRAIN;
         S_DRAIN: if (last_sr[OL-1]) nstate = S_RDY;
         default: nstate = S_RDY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         armed    <= 1'b0;
         win_x    <= '0;
         win_y    <= '0;
         win_size <= 4'(SIZE_INIT);
         mode     <= 2'd0;
         pix_cnt  <= '0;
         row_cnt  <= '0;
         col_cnt  <= '0;
         vld_sr   <= '0;
         last_sr  <= '0;
`ifdef IPDC_MEDIAN_EN
         nb_r     <= '0;
         nb_c     <= '0;
`endif
      end else begin
         armed <= 1'b1;
         if (accept) begin
            win_x    <= nx;
            win_y    <= ny;
            win_size <= ns;
            mode     <= nm;
            pix_cnt  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
`ifdef IPDC_MEDIAN_EN
            nb_r     <= '0;
            nb_c     <= '0;
`endif
         end else begin
            if (in_rdy && i_in_valid) pix_cnt <= pix_cnt + (AW+1)'(1);
`ifdef IPDC_MEDIAN_EN
            if (state == S_DISP && mode == 2'd2) begin
               if (nb_c == 2'd2) begin
                  nb_c <= '0;
                  nb_r <= (nb_r == 2'd2) ? 2'd0 : nb_r + 2'd1;
               end else begin
                  nb_c <= nb_c + 2'd1;
               end
            end
`endif
            if (step_vld) begin
               if (col_cnt == win_size - 4'd1) begin
                  col_cnt <= '0;
                  row_cnt <= row_cnt + 4'd1;
               end else begin
                  col_cnt <= col_cnt + 4'd1;
               end
            end
         end
         vld_sr[0]  <= step_vld;
         last_sr[0] <= step_vld && win_end;
         for (int i = 1; i < OL; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            last_sr[i] <= last_sr[i-1];
         end
      end
   end

   always_comb begin
      o_op_ready  = (state == S_RDY) && armed;
      o_in_ready  = in_rdy;
      o_sram_wen  = in_rdy && i_in_valid;
      o_sram_ren  = 1'b0;
      o_sram_addr = '0;
      o_dp_mode   = mode;
      o_out_valid = vld_sr[OL-1];
      o_out_last  = last_sr[OL-1];
      rd_row      = yw + WW'(row_cnt);
      rd_col      = xw + WW'(col_cnt);
`ifdef IPDC_MEDIAN_EN
      o_rd_pad    = 1'b0;
      // Neighbour coordinates are biased by +1 so row/col -1 stays non-negative.
      prow        = rd_row + WW'(nb_r);
      pcol        = rd_col + WW'(nb_c);
`endif
      if (state == S_LOAD) o_sram_addr = pix_cnt[AW-1:0];
      if (state == S_DISP) begin
`ifdef IPDC_MEDIAN_EN
         if (mode == 2'd2) begin
            if (prow == '0 || pcol == '0 || prow > IMG_WW || pcol > IMG_WW) begin
               o_rd_pad = 1'b1;
            end else begin
               o_sram_ren  = 1'b1;
               o_sram_addr = {prow[LW-1:0] - LW'(1), pcol[LW-1:0] - LW'(1)};
            end
         end else
`endif
         begin
            o_sram_ren  = 1'b1;
            o_sram_addr = {rd_row[LW-1:0], rd_col[LW-1:0]};
         end
      end
   end

endmodule
